// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared state encoding and defaults for the UART transmit arbiter.
package uart_tx_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOW, WAIT_RDY, HOLD} state_t;
    localparam int DEF_NREQ = 4;
    localparam int DEF_HOLD_TIMEOUT = 255;
    localparam int RETRY_LIMIT = 16;
endpackage

// File: rtl/uart_tx_rr_pick.sv
// uart_tx_rr_pick: round-robin winner search starting just after the last grant.
module uart_tx_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] valid,
    input  logic [2:0]      last_grant,
    output logic [2:0]      pick,
    output logic            any
);
    int best;
    // distance from last_grant+1, wrapping; smallest distance wins
    always_comb begin
        best = NREQ;
        pick = last_grant;
        for (int i = 0; i < NREQ; i++)
            if (valid[i] && (i + NREQ - 1 - int'(last_grant)) % NREQ < best) begin
                best = (i + NREQ - 1 - int'(last_grant)) % NREQ;
                pick = 3'(i);
            end
    end
    assign any = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding bytes into a UART transmitter holding register.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    input  logic              txrdy,
    output logic [7:0]        tx_hold_reg,
    output logic              tx_load,
    output logic [2:0]        grant_id,
    output logic              busy
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    state_t state, state_nx;
    logic [2:0] pick;
    logic any, last_flag, reissue, take;
    logic [7:0] hold_cnt;
    logic [4:0] retry_cnt;
    logic [IW-1:0] gid, sel;
    assign gid = grant_id[IW-1:0];
    assign sel = state == IDLE ? pick[IW-1:0] : gid;
    uart_tx_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid(req_valid),
        .last_grant(grant_id),
        .pick(pick),
        .any(any)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (txrdy && any) state_nx = LOAD;
            LOAD:     state_nx = WAIT_LOW;
            WAIT_LOW: if (!txrdy) state_nx = WAIT_RDY;
                      else if (retry_cnt == 5'(RETRY_LIMIT - 1)) state_nx = LOAD;
            WAIT_RDY: if (txrdy) state_nx = last_flag ? IDLE : HOLD;
            HOLD:     if (req_valid[gid] && txrdy) state_nx = LOAD;
                      else if (hold_cnt == 8'(HOLD_TIMEOUT)) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // requester inputs are captured only when leaving IDLE or HOLD; retries reuse the held byte
    assign take      = state_nx == LOAD && (state == IDLE || state == HOLD);
    assign tx_load   = state == LOAD;
    assign req_ready = tx_load && !reissue ? {{(NREQ-1){1'b0}}, 1'b1} << gid : '0;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id    <= 3'(NREQ - 1);
            tx_hold_reg <= 8'h00;
            last_flag   <= 1'b0;
            reissue     <= 1'b0;
            hold_cnt    <= 8'h00;
            retry_cnt   <= 5'd0;
        end else begin
            if (take) begin
                grant_id    <= state == IDLE ? pick : grant_id;
                tx_hold_reg <= req_data[8*sel +: 8];
                last_flag   <= req_last[sel];
            end
            reissue   <= state == WAIT_LOW && state_nx == LOAD;
            retry_cnt <= state == WAIT_LOW ? retry_cnt + 5'd1 : 5'd0;
            hold_cnt  <= state != HOLD ? 8'h00 :
                         (!req_valid[gid] && hold_cnt != 8'(HOLD_TIMEOUT)) ? hold_cnt + 8'd1 : hold_cnt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a simple transmitter model.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int HT = 255;
    typedef struct {
        logic [2:0]   g;
        logic [N-1:0] r;
        logic [7:0]   d;
    } exp_t;
    logic clk = 0, reset_n = 0, txrdy = 1, stuck = 0;
    logic [N-1:0] req_valid = '0, req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic [7:0] tx_hold_reg;
    logic tx_load, busy;
    logic [2:0] grant_id;
    exp_t exp_q[$];
    exp_t e;
    logic [8:0] rq[N][$];
    int checks = 0, errors = 0, cyc = 0, last_load = 0, load_gap = 0, tx_cnt = 0;

    uart_tx_arbiter #(.NREQ(N), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .txrdy(txrdy),
        .tx_hold_reg(tx_hold_reg), .tx_load(tx_load), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor, requester drivers and transmitter model, all away from the active edge
    always @(negedge clk) begin
        if (tx_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load grant=%0d ready=%b data=%h", grant_id, req_ready, tx_hold_reg);
            end else begin
                e = exp_q.pop_front();
                if (grant_id !== e.g || req_ready !== e.r || tx_hold_reg !== e.d) begin
                    errors++;
                    $display("FAIL load grant=%0d ready=%b data=%h expected grant=%0d ready=%b data=%h",
                             grant_id, req_ready, tx_hold_reg, e.g, e.r, e.d);
                end
            end
            load_gap = cyc - last_load;
            last_load = cyc;
        end
        if (!reset_n) begin
            txrdy = 1;
            tx_cnt = 0;
        end else if (tx_load && !stuck) begin
            txrdy = 0;
            tx_cnt = 3;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) txrdy = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            req_valid[i] = rq[i].size() != 0;
            if (req_valid[i]) begin
                req_last[i] = rq[i][0][8];
                req_data[8*i +: 8] = rq[i][0][7:0];
            end else begin
                req_last[i] = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic push(int i, bit last, logic [7:0] d);
        rq[i].push_back({last, d});
    endtask

    task automatic expect_load(int g, logic [7:0] d, bit rdy);
        exp_t x;
        x.g = 3'(g);
        x.r = rdy ? 4'(1 << g) : '0;
        x.d = d;
        exp_q.push_back(x);
    endtask

    task automatic wait_q(string name, int lvl, int maxc);
        int n = 0;
        while (exp_q.size() > lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s timeout pending=%0d", name, exp_q.size());
        end
    endtask

    task automatic wait_drain(string name, int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s timeout pending=%0d busy=%b", name, exp_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        stuck = 0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("rst_tx_load", tx_load, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_hold_reg", tx_hold_reg, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 3);

        @(posedge clk) #1;
        push(2, 1, 8'hA5);
        expect_load(2, 8'hA5, 1);
        @(negedge clk);
        @(negedge clk);
        chk("single_tx_load", tx_load, 1);
        chk("single_ready", req_ready, 4'b0100);
        chk("single_data", tx_hold_reg, 8'hA5);
        wait_drain("single", 50);
        chk("single_busy", busy, 0);
        chk("single_grant", grant_id, 2);

        do_reset();
        @(posedge clk) #1;
        for (int i = 0; i < N; i++) for (int j = 0; j < 2; j++) push(i, 1, {4'(i), 4'(j)});
        for (int j = 0; j < 2; j++) for (int i = 0; i < N; i++) expect_load(i, {4'(i), 4'(j)}, 1);
        wait_drain("fairness", 300);

        do_reset();
        @(posedge clk) #1;
        push(1, 0, 8'h11);
        push(1, 0, 8'h12);
        push(1, 1, 8'h13);
        expect_load(1, 8'h11, 1);
        expect_load(1, 8'h12, 1);
        expect_load(1, 8'h13, 1);
        expect_load(0, 8'h01, 1);
        wait_q("lock_first", 3, 50);
        push(0, 1, 8'h01);
        wait_drain("lock", 200);

        do_reset();
        @(posedge clk) #1;
        push(3, 0, 8'h3C);
        expect_load(3, 8'h3C, 1);
        expect_load(0, 8'h0F, 1);
        wait_q("timeout_first", 1, 50);
        push(0, 1, 8'h0F);
        wait_drain("timeout", 600);
        chk("timeout_gap_min", load_gap > HT, 1);
        chk("timeout_gap_max", load_gap < HT + 12, 1);

        do_reset();
        stuck = 1;
        @(posedge clk) #1;
        push(0, 1, 8'h5A);
        expect_load(0, 8'h5A, 1);
        expect_load(0, 8'h5A, 0);
        expect_load(0, 8'h5A, 0);
        wait_q("stuck_retry", 1, 100);
        chk("stuck_gap1", load_gap, 17);
        stuck = 0;
        wait_drain("stuck", 100);
        chk("stuck_gap2", load_gap, 17);

        do_reset();
        @(posedge clk) #1;
        push(1, 0, 8'h77);
        expect_load(1, 8'h77, 1);
        wait_q("wrdy_load", 0, 50);
        @(posedge clk);
        @(posedge clk) #1;
        chk("wrdy_busy_pre", busy, 1);
        chk("wrdy_txrdy_low", txrdy, 0);
        reset_n = 0;
        #1;
        chk("wrdy_rst_tx_load", tx_load, 0);
        chk("wrdy_rst_ready", req_ready, 0);
        chk("wrdy_rst_data", tx_hold_reg, 8'h00);
        chk("wrdy_rst_busy", busy, 0);
        chk("wrdy_rst_grant", grant_id, 3);
        for (int i = 0; i < N; i++) rq[i].delete();
        @(negedge clk);
        reset_n = 1;
        repeat (20) @(negedge clk);
        chk("wrdy_post_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_TIMEOUT, default 255: idle cycles tolerated mid-packet before the lock is forced open; legal range 1..255.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester byte available.
REQ-006 req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  in  NREQ  byte presented is the final byte of its packet.
REQ-008 req_ready  out  NREQ  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-009 txrdy  in  1  transmitter holding register free (high = free).
REQ-010 tx_hold_reg  out  8  byte to transmitter; drives the transmitter holding-register input.
REQ-011 tx_load  out  1  one-cycle strobe to the transmitter's rst_tx_empty input.
REQ-012 grant_id  out  3  index of current/last granted requester.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, LOAD, WAIT_LOW, WAIT_RDY, HOLD.
- IDLE -> LOAD when txrdy=1 and any req_valid=1.
- LOAD -> WAIT_LOW, unconditional.
- WAIT_LOW -> WAIT_RDY when txrdy=0.
- WAIT_RDY -> IDLE when txrdy=1 and the accepted byte had req_last=1.
- WAIT_RDY -> HOLD when txrdy=1 and the accepted byte had req_last=0.
- HOLD -> LOAD when req_valid[grant_id]=1 and txrdy=1.
- HOLD -> IDLE when the hold counter reaches HOLD_TIMEOUT.
REQ-015 Arbitration in IDLE is round-robin: search starts at (grant_id+1) mod NREQ, wraps, and picks the first requester with req_valid=1; the winner is registered into grant_id on the IDLE->LOAD edge.
REQ-016 In LOAD, for exactly one cycle:
- tx_load=1;
- req_ready[grant_id]=1;
- req_data of grant_id captured into tx_hold_reg;
- req_last of grant_id captured into an internal last flag.
REQ-017 Acceptance latency: a byte presented to an idle arbiter with txrdy=1 is accepted 1 cycle after req_valid is sampled (IDLE edge, then LOAD cycle).
REQ-018 tx_hold_reg holds its value from LOAD until the next LOAD; it never changes while txrdy=0.
REQ-019 Packet lock: in HOLD only grant_id is serviced; other requesters' req_valid is ignored until HOLD exits.
REQ-020 Hold counter (8-bit):
- cleared on entry to HOLD;
- increments each HOLD cycle with req_valid[grant_id]=0;
- saturates at HOLD_TIMEOUT and forces HOLD->IDLE;
- after a forced exit, arbitration resumes from grant_id+1.
REQ-021 If WAIT_LOW sees txrdy=1 for 16 consecutive cycles (transmitter did not take the load), the FSM returns to LOAD and re-issues tx_load with the same byte; req_ready is not re-pulsed.
REQ-022 Requester inputs are sampled only in IDLE and HOLD; changes during LOAD/WAIT_* have no effect.
REQ-023 Simultaneous req_valid with req_last=1 from the granted requester and another requester: the packet closes, then the other requester wins the next IDLE arbitration.
REQ-024 At most one tx_load per transmitted byte; req_ready is never multi-hot.

Reset
REQ-025 On reset_n=0, asynchronously:
- state=IDLE;
- tx_load=0, req_ready=0, tx_hold_reg=8'h00, busy=0;
- grant_id=NREQ-1, so that requester 0 wins first;
- hold and retry counters=0;
- last flag=0.
REQ-026 Reset asserted mid-packet abandons the packet; no tx_load is issued until after reset deassertion.

Structure
REQ-027 The shared package holds: state encoding constants, default NREQ, the HOLD_TIMEOUT default, and the WAIT_LOW retry limit (16).
REQ-028 The round-robin search is a combinational sub-module uart_tx_rr_pick; inputs are the valid vector and last grant, outputs are the winner index and any-valid.

Verification
REQ-029 Single byte: req_valid[2]=1, data=8'hA5, last=1, txrdy=1 -> one cycle later tx_load=1, req_ready=4'b0100, tx_hold_reg=8'hA5; after txrdy falls and rises, busy=0.
REQ-030 Fairness: all four requesters continuously valid with last=1 -> grant order 0,1,2,3,0 across five bytes.
REQ-031 Packet lock: requester 1 sends 3 bytes (last on the 3rd) while requester 0 stays valid -> grants 1,1,1, then 0.
REQ-032 Timeout: requester 3 sends a byte with last=0, then drops valid for 255 cycles -> HOLD exits to IDLE and requester 0 is granted next.
REQ-033 Stuck transmitter: txrdy held at 1 after tx_load -> tx_load re-pulsed after 16 cycles with the same byte and no second req_ready.
REQ-034 Reset in WAIT_RDY: all outputs return to reset values immediately, and grant_id=NREQ-1.
